bvslt_bvmul_checker: RTL and testbench

Sequential checker for synthesized Skolem witnesses of the `bvslt`/`bvmul` family. It accepts one W-bit signed operand triple (a, b, c) plus the 1-bit witness value that the combinational Skolem function produced for it. It then recomputes `(a*b mod 2^W) <s c` with a bit-serial shift-add multiplier and a signed compare, and reports the true value and whether the witness disagrees. It sits downstream of the Skolem-function netlists in the equivalence and regression harness.

---
 rtl/bvchk_pkg.sv | 17 +
 rtl/bv_serial_mul.sv | 70 +++++++
 rtl/bvslt_bvmul_checker.sv | 142 ++++++++++++++
 tb/tb_bvslt_bvmul_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bvchk_pkg.sv
// rtl/bvchk_pkg.sv - shared types and constants for the bvslt/bvmul witness checker
//
// Contents:
//   bvchk_state_t : checker FSM states (IDLE, MUL, CMP, DONE)
//   BVCHK_W_DEF   : default operand width in bits
package bvchk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } bvchk_state_t;

    localparam int BVCHK_W_DEF = 4;

endpackage : bvchk_pkg

// File: rtl/bv_serial_mul.sv
// rtl/bv_serial_mul.sv - bit-serial shift-add multiplier, product truncated to W bits
//
// Ports:
//   clk      in  1 : clock, rising edge
//   rst_n    in  1 : asynchronous active-low reset
//   start    in  1 : latch a/b and begin a multiply (ignored while busy)
//   a        in  W : multiplicand
//   b        in  W : multiplier, consumed one bit per cycle, LSB first
//   busy     out 1 : a multiply is in progress
//   done     out 1 : this cycle processes the last multiplier bit
//   product  out W : accumulator; the final product once busy drops
module bv_serial_mul #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    // W >= 2 so the index width is never zero
    localparam int KW = $clog2(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_acc;
    logic [KW-1:0] r_k;
    logic          r_busy;

    // a << k is already W bits wide, so the add wraps mod 2^W for free;
    // this gives bvmul semantics for signed and unsigned operands alike
    logic [W-1:0] w_partial;
    assign w_partial = r_a << r_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_k    <= '0;
            r_busy <= 1'b0;
        end else if (start && !r_busy) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_k    <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_b[r_k]) begin
                r_acc <= r_acc + w_partial;
            end
            if (r_k == K_LAST) begin
                r_k    <= '0;
                r_busy <= 1'b0;
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_busy && (r_k == K_LAST);
    assign product = r_acc;

endmodule : bv_serial_mul

// File: rtl/bvslt_bvmul_checker.sv
// rtl/bvslt_bvmul_checker.sv - recomputes (a*b mod 2^W) <s c and flags disagreeing witness bits
//
// Ports:
//   clk          in  1     : clock, rising edge
//   rst_n        in  1     : asynchronous active-low reset
//   in_valid     in  1     : operand triple and claim are valid
//   in_ready     out 1     : block accepts a transaction (IDLE only, low in reset)
//   a, b, c      in  W     : signed two's-complement operands
//   claim        in  1     : witness bit from the Skolem function under test
//   out_valid    out 1     : result / mismatch are valid
//   out_ready    in  1     : consumer accepts the result
//   result       out 1     : true value of (a*b)[W-1:0] <s c
//   mismatch     out 1     : result ^ claim
//   mismatch_cnt out CNT_W : mismatching results accepted by consumer, saturating
module bvslt_bvmul_checker
    import bvchk_pkg::*;
#(
    parameter int W     = BVCHK_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic             claim,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    bvchk_state_t r_state;
    bvchk_state_t w_next_state;

    logic [W-1:0]     r_c;
    logic             r_claim;
    logic             r_result;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_mismatch_cnt;

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_accept;
    logic         w_handshake;
    logic         w_mul_busy;
    logic         w_mul_done;
    logic [W-1:0] w_product;
    logic         w_slt;

    // The multiplier holds a and b; the checker keeps only c and the claim
    bv_serial_mul #(
        .W (W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    assign w_slt = $signed(w_product) < $signed(r_c);

    // in_ready is gated by rst_n so it reads 0 while reset is held,
    // even though the state register already sits in IDLE
    always_comb begin
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                w_in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_next_state = MUL;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_next_state = CMP;
                end
            end
            CMP: begin
                w_next_state = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept    = w_in_ready && in_valid && !w_mul_busy;
    assign w_handshake = w_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c            <= '0;
            r_claim        <= 1'b0;
            r_result       <= 1'b0;
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_c     <= c;
                r_claim <= claim;
            end
            if (r_state == CMP) begin
                r_result   <= w_slt;
                r_mismatch <= w_slt ^ r_claim;
            end
            if (w_handshake && r_mismatch && (r_mismatch_cnt != {CNT_W{1'b1}})) begin
                r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign result       = r_result;
    assign mismatch     = r_mismatch;
    assign mismatch_cnt = r_mismatch_cnt;

endmodule : bvslt_bvmul_checker

// File: tb/tb_bvslt_bvmul_checker.sv
// tb/tb_bvslt_bvmul_checker.sv - directed self-checking bench for bvslt_bvmul_checker
module tb_bvslt_bvmul_checker;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic             claim;
    logic             out_valid;
    logic             out_ready;
    logic             result;
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_cnt;

    int n_checks;
    int n_errors;

    bvslt_bvmul_checker #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .c            (c),
        .claim        (claim),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .mismatch     (mismatch),
        .mismatch_cnt (mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one transaction, and returns
    // the number of edges from accept until out_valid (-1 on timeout).
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] tc, input logic tclaim, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        a        = ta;
        b        = tb_;
        c        = tc;
        claim    = tclaim;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (mismatch_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: got %0d expected 0", mismatch_cnt);
        end
        n_checks++;
        if (result !== 1'b0 || mismatch !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_result: got result=%b mismatch=%b expected 0/0", result, mismatch);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    // 3*5 = 15 = 4'b1111 = -1, and -1 <s 0
    task automatic test_pos_overflow();
        int lat;
        send(4'd3, 4'd5, 4'd0, 1'b1, lat);
        n_checks++;
        if (lat !== 5) begin
            n_errors++;
            $display("FAIL pos_ovf_latency: got %0d expected 5", lat);
        end
        n_checks++;
        if (result !== 1'b1 || mismatch !== 1'b0) begin
            n_errors++;
            $display("FAIL pos_ovf_result: got result=%b mismatch=%b expected 1/0", result, mismatch);
        end
        accept_out();
        n_checks++;
        if (mismatch_cnt !== 8'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL pos_ovf_after: got cnt=%0d in_ready=%b out_valid=%b expected 0/1/0",
                     mismatch_cnt, in_ready, out_valid);
        end
    endtask

    // -2*3 = -6 (4'hA), -6 <s -7 is false
    task automatic test_negative();
        int lat;
        send(4'hE, 4'd3, 4'h9, 1'b1, lat);
        n_checks++;
        if (lat !== 5 || result !== 1'b0 || mismatch !== 1'b1) begin
            n_errors++;
            $display("FAIL negative_result: got lat=%0d result=%b mismatch=%b expected 5/0/1",
                     lat, result, mismatch);
        end
        n_checks++;
        if (mismatch_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL negative_cnt_before: got %0d expected 0", mismatch_cnt);
        end
        accept_out();
        n_checks++;
        if (mismatch_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL negative_cnt: got %0d expected 1", mismatch_cnt);
        end
    endtask

    // 4*4 = 16 wraps to 0, 0 <s 1
    task automatic test_wrap();
        int lat;
        send(4'd4, 4'd4, 4'd1, 1'b0, lat);
        n_checks++;
        if (lat !== 5 || result !== 1'b1 || mismatch !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_result: got lat=%0d result=%b mismatch=%b expected 5/1/1",
                     lat, result, mismatch);
        end
        accept_out();
        n_checks++;
        if (mismatch_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL wrap_cnt: got %0d expected 2", mismatch_cnt);
        end
    endtask

    // 2*(-1) = -2, -2 <s 0; held in DONE while new inputs are offered
    task automatic test_backpressure();
        int lat;
        int bad;
        send(4'd2, 4'hF, 4'd0, 1'b0, lat);
        bad = 0;
        a        = 4'd7;
        b        = 4'd7;
        c        = 4'd7;
        claim    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b1 || result !== 1'b1 || mismatch !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles, last out_valid=%b result=%b mismatch=%b in_ready=%b expected 1/1/1/0",
                     bad, out_valid, result, mismatch, in_ready);
        end
        in_valid = 1'b0;
        accept_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mismatch_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL backpressure_release: got out_valid=%b in_ready=%b cnt=%0d expected 0/1/3",
                     out_valid, in_ready, mismatch_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        a        = 4'd4;
        b        = 4'd4;
        c        = 4'd1;
        claim    = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || mismatch_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL midreset_values: got in_ready=%b out_valid=%b cnt=%0d expected 0/0/0",
                     in_ready, out_valid, mismatch_cnt);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL midreset_no_output: out_valid high %0d cycles expected 0", seen);
        end
        send(4'd3, 4'd5, 4'd0, 1'b1, lat);
        n_checks++;
        if (lat !== 5 || result !== 1'b1 || mismatch !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_next: got lat=%0d result=%b mismatch=%b expected 5/1/0",
                     lat, result, mismatch);
        end
        accept_out();
    endtask

    task automatic test_saturation();
        int lat;
        int exp_cnt;
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            send(4'd4, 4'd4, 4'd1, 1'b0, lat);
            accept_out();
            if (exp_cnt < 255) exp_cnt++;
            if (i == 0 || i == 253 || i == 254 || i == 299) begin
                n_checks++;
                if (mismatch_cnt !== exp_cnt[CNT_W-1:0]) begin
                    n_errors++;
                    $display("FAIL saturation_cnt_%0d: got %0d expected %0d", i, mismatch_cnt, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c         = '0;
        claim     = 1'b0;

        test_reset();
        test_pos_overflow();
        test_negative();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bvslt_bvmul_checker
